inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
Instruction fetch stage. It is the producer end of the instruction interface that the decode stage consumes.
- Holds the PC and issues one aligned 32-bit fetch at a time over a valid/ready memory request/response port.
- Presents the fetched word plus its PC to decode under a valid/ready handshake.
- Accepts PC redirects (jal/jalr, pc_wen) from the execute side.

Parameters:
XLEN, 64, PC and address width
INST_LEN, 32, instruction width
RESET_PC, 64'h0000_0000_8000_0000, PC loaded on reset

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous reset, active-low (0 = reset), sampled on rising edge of clk
mem_req_valid  output  1  fetch request valid
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  XLEN  fetch address (equals pc)
mem_rsp_valid  input  1  response valid (single cycle pulse per accepted request)
mem_rsp_data  input  INST_LEN  fetched word
mem_rsp_err  input  1  access fault, qualified by mem_rsp_valid
inst_valid  output  1  instruction available to decode
inst_ready  input  1  decode consumes instruction
inst  output  INST_LEN  instruction word
inst_pc  output  XLEN  PC of inst
inst_fault  output  1  inst is a fault marker (access error or misaligned PC)
redirect  input  1  PC write enable from execute (pc_wen)
redirect_pc  input  XLEN  redirect target

Behaviour:
- States: REQ, WAIT, HOLD, FLUSH. At most one request is outstanding.
- Reset (rst==0 at posedge):
  - state=REQ, pc=RESET_PC.
  - inst_valid=0, inst=0, inst_pc=0, inst_fault=0.
  - Outputs are registered/Moore, so mem_req_valid=0 while rst==0.
- mem_req_valid = (state==REQ) && pc[1:0]==0 && rst. mem_req_addr = pc.
  - Address is stable while valid and unaccepted, except on redirect.
- REQ, aligned pc:
  - mem_req_ready=1 → WAIT.
  - Otherwise stay in REQ.
- REQ, misaligned pc (pc[1:0]!=0):
  - No request is issued.
  - Next cycle: HOLD, inst_valid=1, inst=0, inst_pc=pc, inst_fault=1.
- WAIT: on mem_rsp_valid, next cycle state=HOLD and:
  - inst_valid=1, inst_pc=pc, inst_fault=mem_rsp_err.
  - inst = mem_rsp_err ? 0 : mem_rsp_data.
- Response latency: the earliest mem_rsp_valid is the cycle after acceptance. Minimum accept-to-inst_valid latency is 2 cycles.
- HOLD: inst, inst_pc and inst_fault stay stable until inst_valid && inst_ready. On that handshake:
  - inst_valid←0, state←REQ.
  - pc←pc+4, wrapping modulo 2^XLEN.
- Redirect has highest priority. redirect==1 at a posedge sets pc←redirect_pc, then per state:
  - HOLD: inst_valid←0, →REQ. If inst_ready is high in the same cycle, the handshake counts as consumed, but pc takes redirect_pc, not pc+4.
  - REQ with the request accepted in that same cycle: →FLUSH.
  - REQ, not accepted: stay REQ; the new address is presented next cycle.
  - WAIT without mem_rsp_valid: →FLUSH.
  - WAIT with mem_rsp_valid: the response is discarded, →REQ.
  - FLUSH: pc updated, stay FLUSH.
- FLUSH: on mem_rsp_valid the data is discarded, →REQ. inst_valid stays 0.
- mem_rsp_valid in REQ or HOLD is a protocol violation: ignored, no state change.
- Reset mid-operation overrides everything. Any in-flight response arriving after reset is ignored, because state is REQ.
- There is no timeout on WAIT or FLUSH.

Decomposition:
- Shared package:
  - State encoding localparams (REQ=2'd0, WAIT=2'd1, HOLD=2'd2, FLUSH=2'd3).
  - Default RESET_PC.
  - INST_BYTES=4.
  - FAULT_INST=32'h0.
- One sub-module: fetch_pc_reg. XLEN register with synchronous active-low reset to RESET_PC, write enable, and a next-value mux (redirect_pc / pc+4).

Test Plan:
- Reset then memory always ready with 1-cycle response: req addr 0x80000000 at cycle 1, inst_valid at cycle 3 with inst_pc=0x80000000. Next req addr 0x80000004.
- Decode holds inst_ready=0 for 5 cycles in HOLD: inst and inst_pc stay unchanged and no new mem_req_valid. Release gives one handshake and the next fetch at pc+4.
- Redirect to 0x80000100 in WAIT, stale response data 0xDEADBEEF arrives 3 cycles later: that word is never presented. Next req addr is 0x80000100.
- Redirect coinciding with the inst_ready handshake in HOLD, target 0x80000040: next req addr 0x80000040, not pc+4.
- Redirect to 0x80000102: no mem request; inst_valid=1, inst_fault=1, inst=0, inst_pc=0x80000102.
- mem_rsp_err=1 on a response: inst_fault=1, inst=0. Assert rst=0 while in WAIT: the next cycle after release requests 0x80000000 and the late response is ignored.

Source files
------------

// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding, reset PC,
// fault-marker word and the alignment helper.
package inst_fetch_unit_pkg;

  localparam logic [1:0] ST_REQ   = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  typedef enum logic [1:0] {
    S_REQ   = ST_REQ,
    S_WAIT  = ST_WAIT,
    S_HOLD  = ST_HOLD,
    S_FLUSH = ST_FLUSH
  } fetch_state_t;

  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;
  localparam int          INST_BYTES       = 4;
  localparam logic [31:0] FAULT_INST       = 32'h0000_0000;

  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: loads RESET_PC on reset, and on write enable takes
// either the redirect target or the sequential pc+4 (wrapping).
module fetch_pc_reg
  import inst_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_wen,
  input  logic            i_sel_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic [XLEN-1:0] o_pc
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;

  assign w_pc_nxt = i_sel_redirect ? i_redirect_pc : (r_pc + XLEN'(INST_BYTES));

  // PC state update with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc <= RESET_PC;
    end else if (i_wen) begin
      r_pc <= w_pc_nxt;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: one outstanding aligned fetch at a time, presents the
// word and its PC to decode, and honours redirects from execute.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              INST_LEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [XLEN-1:0]     mem_req_addr,
  input  logic                mem_rsp_valid,
  input  logic [INST_LEN-1:0] mem_rsp_data,
  input  logic                mem_rsp_err,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [INST_LEN-1:0] inst,
  output logic [XLEN-1:0]     inst_pc,
  output logic                inst_fault,
  input  logic                redirect,
  input  logic [XLEN-1:0]     redirect_pc
);

  fetch_state_t        r_state, w_state_nxt;
  logic                r_inst_valid, w_inst_valid_nxt;
  logic [INST_LEN-1:0] r_inst, w_inst_nxt;
  logic [XLEN-1:0]     r_inst_pc, w_inst_pc_nxt;
  logic                r_inst_fault, w_inst_fault_nxt;
  logic                w_pc_wen;
  logic                w_pc_sel_redirect;
  logic [XLEN-1:0]     w_pc;
  logic                w_aligned;
  logic                w_req_fire;

  fetch_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk            (clk),
    .rst            (rst),
    .i_wen          (w_pc_wen),
    .i_sel_redirect (w_pc_sel_redirect),
    .i_redirect_pc  (redirect_pc),
    .o_pc           (w_pc)
  );

  assign w_aligned     = is_word_aligned(w_pc[1:0]);
  assign mem_req_valid = (r_state == S_REQ) && w_aligned && rst;
  assign mem_req_addr  = w_pc;
  assign w_req_fire    = mem_req_valid && mem_req_ready;

  // State, PC-update and decode-side output selection; redirect wins over all
  always_comb begin
    w_state_nxt       = r_state;
    w_inst_valid_nxt  = r_inst_valid;
    w_inst_nxt        = r_inst;
    w_inst_pc_nxt     = r_inst_pc;
    w_inst_fault_nxt  = r_inst_fault;
    w_pc_wen          = redirect;
    w_pc_sel_redirect = redirect;
    case (r_state)
      S_REQ: begin
        if (redirect) begin
          w_state_nxt = w_req_fire ? S_FLUSH : S_REQ;
        end else if (!w_aligned) begin
          w_state_nxt      = S_HOLD;
          w_inst_valid_nxt = 1'b1;
          w_inst_nxt       = INST_LEN'(FAULT_INST);
          w_inst_pc_nxt    = w_pc;
          w_inst_fault_nxt = 1'b1;
        end else if (mem_req_ready) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          w_state_nxt = mem_rsp_valid ? S_REQ : S_FLUSH;
        end else if (mem_rsp_valid) begin
          w_state_nxt      = S_HOLD;
          w_inst_valid_nxt = 1'b1;
          w_inst_nxt       = mem_rsp_err ? INST_LEN'(FAULT_INST) : mem_rsp_data;
          w_inst_pc_nxt    = w_pc;
          w_inst_fault_nxt = mem_rsp_err;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_HOLD: begin
        if (redirect || inst_ready) begin
          w_state_nxt      = S_REQ;
          w_inst_valid_nxt = 1'b0;
          w_pc_wen         = 1'b1;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      S_FLUSH: begin
        // The orphaned response may coincide with a new redirect; it still closes the flush
        if (mem_rsp_valid) begin
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_FLUSH;
        end
      end
      default: begin
        w_state_nxt      = S_REQ;
        w_inst_valid_nxt = 1'b0;
      end
    endcase
  end

  // Registered FSM state and decode-side outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_REQ;
      r_inst_valid <= 1'b0;
      r_inst       <= '0;
      r_inst_pc    <= '0;
      r_inst_fault <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_inst_valid <= w_inst_valid_nxt;
      r_inst       <= w_inst_nxt;
      r_inst_pc    <= w_inst_pc_nxt;
      r_inst_fault <= w_inst_fault_nxt;
    end
  end

  assign inst_valid = r_inst_valid;
  assign inst       = r_inst;
  assign inst_pc    = r_inst_pc;
  assign inst_fault = r_inst_fault;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed table-driven bench for inst_fetch_unit with hand-computed expectations.
module tb_inst_fetch_unit;

  localparam logic [63:0] A = 64'h0000_0000_8000_0000;

  logic        clk;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        inst_fault;
  logic        redirect;
  logic [63:0] redirect_pc;

  int n_pass;
  int n_total;

  typedef struct {
    logic        rst;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        inst_ready;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        e_req_valid;
    logic [63:0] e_req_addr;
    logic        e_inst_valid;
    logic [31:0] e_inst;
    logic [63:0] e_inst_pc;
    logic        e_fault;
  } vec_t;

  vec_t vecs[$];

  inst_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_err   (mem_rsp_err),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_fault    (inst_fault),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic r, input logic rdy, input logic rv, input logic [31:0] rd, input logic re,
    input logic ir, input logic rdr, input logic [63:0] rpc,
    input logic erv, input logic [63:0] ea, input logic eiv, input logic [31:0] ei,
    input logic [63:0] eipc, input logic ef);
    vec_t v;
    v.rst = r; v.req_ready = rdy; v.rsp_valid = rv; v.rsp_data = rd; v.rsp_err = re;
    v.inst_ready = ir; v.redirect = rdr; v.redirect_pc = rpc;
    v.e_req_valid = erv; v.e_req_addr = ea; v.e_inst_valid = eiv; v.e_inst = ei;
    v.e_inst_pc = eipc; v.e_fault = ef;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL vec%0d %s: got %h expected %h", idx, name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Apply one vector's inputs, compare outputs, then advance one clock
  task automatic run_vec(input vec_t v, input int idx);
    rst           = v.rst;
    mem_req_ready = v.req_ready;
    mem_rsp_valid = v.rsp_valid;
    mem_rsp_data  = v.rsp_data;
    mem_rsp_err   = v.rsp_err;
    inst_ready    = v.inst_ready;
    redirect      = v.redirect;
    redirect_pc   = v.redirect_pc;
    #1;
    chk("mem_req_valid", idx, {63'd0, mem_req_valid}, {63'd0, v.e_req_valid});
    chk("mem_req_addr",  idx, mem_req_addr, v.e_req_addr);
    chk("inst_valid",    idx, {63'd0, inst_valid}, {63'd0, v.e_inst_valid});
    chk("inst",          idx, {32'd0, inst}, {32'd0, v.e_inst});
    chk("inst_pc",       idx, inst_pc, v.e_inst_pc);
    chk("inst_fault",    idx, {63'd0, inst_fault}, {63'd0, v.e_fault});
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
    mem_rsp_err = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 64'h0;
    @(posedge clk);
    @(posedge clk);
    #1;

    //        rst  rdy  rv   data          err  ir   rdr  rpc                       erv  eaddr                     eiv  einst         eipc          ef
    vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,64'h0,                  1'b0,A,                        1'b0,32'h0,        64'h0,        1'b0)); // 0 reset state
    vecs.push_back(mk(1'b1,1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,64'h0,                  1'b1,A,                        1'b0,32'h0,        64'h0,        1'b0)); // 1 first request
    vecs.push_back(mk(1'b1,1'b1,1'b1,32'h0000_0013,1'b0,1'b0,1'b0,64'h0,                  1'b0,A,                        1'b0,32'h0,        64'h0,        1'b0)); // 2 wait, response
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,      1'b0,1'b0,1'b0,64'h0,                  1'b0,A,                        1'b1,32'h0000_0013,A,            1'b0)); // 3-7 hold stalled
    vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,1'b0,64'h0,                  1'b0,A,                        1'b1,32'h0000_0013,A,            1'b0)); // 8 handshake
    vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,64'h0,                  1'b1,A+64'h4,                  1'b0,32'h0000_0013,A,            1'b0)); // 9 pc+4, not ready
    vecs.push_back(mk(1'b1,1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,64'h0,                  1'b1,A+64'h4,                  1'b0,32'h0000_0013,A,            1'b0)); // 10 accepted
    vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,A+64'h100,              1'b0,A+64'h4,                  1'b0,32'h0000_0013,A,            1'b0)); // 11 redirect in WAIT
    vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,64'h0,                  1'b0,A+64'h100,                1'b0,32'h0000_0013,A,            1'b0)); // 12 flush
    vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,64'h0,                  1'b0,A+64'h100,                1'b0,32'h0000_0013,A,            1'b0)); // 13 flush
    vecs.push_back(mk(1'b1,1'b0,1'b1,32'hDEAD_BEEF,1'b0,1'b0,1'b0,64'h0,                  1'b0,A+64'h100,                1'b0,32'h0000_0013,A,            1'b0)); // 14 stale data
    vecs.push_back(mk(1'b1,1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,64'h0,                  1'b1,A+64'h100,                1'b0,32'h0000_0013,A,            1'b0)); // 15 refetch target
    vecs.push_back(mk(1'b1,1'b0,1'b1,32'h1111_1111,1'b0,1'b0,1'b0,64'h0,                  1'b0,A+64'h100,                1'b0,32'h0000_0013,A,            1'b0)); // 16 response
    vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,1'b1,A+64'h40,               1'b0,A+64'h100,                1'b1,32'h1111_1111,A+64'h100,    1'b0)); // 17 redirect+handshake
    vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,64'h0,                  1'b1,A+64'h40,                 1'b0,32'h1111_1111,A+64'h100,    1'b0)); // 18 target not pc+4
    vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,A+64'h102,              1'b1,A+64'h40,                 1'b0,32'h1111_1111,A+64'h100,    1'b0)); // 19 redirect misaligned
    vecs.push_back(mk(1'b1,1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,64'h0,                  1'b0,A+64'h102,                1'b0,32'h1111_1111,A+64'h100,    1'b0)); // 20 no request
    vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,64'h0,                  1'b0,A+64'h102,                1'b1,32'h0,        A+64'h102,    1'b1)); // 21 fault marker
    vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,A+64'h200,              1'b0,A+64'h102,                1'b1,32'h0,        A+64'h102,    1'b1)); // 22 redirect in HOLD
    vecs.push_back(mk(1'b1,1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,64'h0,                  1'b1,A+64'h200,                1'b0,32'h0,        A+64'h102,    1'b1)); // 23 request
    vecs.push_back(mk(1'b1,1'b0,1'b1,32'hCAFE_F00D,1'b1,1'b0,1'b0,64'h0,                  1'b0,A+64'h200,                1'b0,32'h0,        A+64'h102,    1'b1)); // 24 error response
    vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,1'b0,64'h0,                  1'b0,A+64'h200,                1'b1,32'h0,        A+64'h200,    1'b1)); // 25 fault presented
    vecs.push_back(mk(1'b1,1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,64'h0,                  1'b1,A+64'h204,                1'b0,32'h0,        A+64'h200,    1'b1)); // 26 request
    vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,64'h0,                  1'b0,A+64'h204,                1'b0,32'h0,        A+64'h200,    1'b1)); // 27 reset in WAIT
    vecs.push_back(mk(1'b1,1'b0,1'b1,32'h1234_5678,1'b0,1'b0,1'b0,64'h0,                  1'b1,A,                        1'b0,32'h0,        64'h0,        1'b0)); // 28 late rsp ignored
    vecs.push_back(mk(1'b1,1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,64'h0,                  1'b1,A,                        1'b0,32'h0,        64'h0,        1'b0)); // 29 request
    vecs.push_back(mk(1'b1,1'b0,1'b1,32'hABCD_0001,1'b0,1'b0,1'b0,64'h0,                  1'b0,A,                        1'b0,32'h0,        64'h0,        1'b0)); // 30 response
    vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,1'b0,64'h0,                  1'b0,A,                        1'b1,32'hABCD_0001,A,            1'b0)); // 31 handshake
    vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,64'hFFFF_FFFF_FFFF_FFFC,1'b1,A+64'h4,                  1'b0,32'hABCD_0001,A,            1'b0)); // 32 redirect to top
    vecs.push_back(mk(1'b1,1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,64'h0,                  1'b1,64'hFFFF_FFFF_FFFF_FFFC,  1'b0,32'hABCD_0001,A,            1'b0)); // 33 request
    vecs.push_back(mk(1'b1,1'b0,1'b1,32'h0000_0073,1'b0,1'b0,1'b0,64'h0,                  1'b0,64'hFFFF_FFFF_FFFF_FFFC,  1'b0,32'hABCD_0001,A,            1'b0)); // 34 response
    vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,1'b0,64'h0,                  1'b0,64'hFFFF_FFFF_FFFF_FFFC,  1'b1,32'h0000_0073,64'hFFFF_FFFF_FFFF_FFFC,1'b0)); // 35 handshake
    vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,64'h0,                  1'b1,64'h0,                    1'b0,32'h0000_0073,64'hFFFF_FFFF_FFFF_FFFC,1'b0)); // 36 pc wrapped

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Redirect on the cycle the request is accepted, then a stray response while holding
    run_vec(mk(1'b1,1'b1,1'b0,32'h0,        1'b0,1'b0,1'b1,A+64'h300,1'b1,64'h0,    1'b0,32'h0000_0073,64'hFFFF_FFFF_FFFF_FFFC,1'b0), 100);
    run_vec(mk(1'b1,1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,64'h0,    1'b0,A+64'h300,1'b0,32'h0000_0073,64'hFFFF_FFFF_FFFF_FFFC,1'b0), 101);
    run_vec(mk(1'b1,1'b0,1'b1,32'h5555_5555,1'b0,1'b0,1'b0,64'h0,    1'b0,A+64'h300,1'b0,32'h0000_0073,64'hFFFF_FFFF_FFFF_FFFC,1'b0), 102);
    run_vec(mk(1'b1,1'b1,1'b0,32'h0,        1'b0,1'b0,1'b0,64'h0,    1'b1,A+64'h300,1'b0,32'h0000_0073,64'hFFFF_FFFF_FFFF_FFFC,1'b0), 103);
    run_vec(mk(1'b1,1'b0,1'b1,32'h6666_6666,1'b0,1'b0,1'b0,64'h0,    1'b0,A+64'h300,1'b0,32'h0000_0073,64'hFFFF_FFFF_FFFF_FFFC,1'b0), 104);
    run_vec(mk(1'b1,1'b0,1'b1,32'h7777_7777,1'b0,1'b0,1'b0,64'h0,    1'b0,A+64'h300,1'b1,32'h6666_6666,A+64'h300,             1'b0), 105);
    run_vec(mk(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b1,1'b0,64'h0,    1'b0,A+64'h300,1'b1,32'h6666_6666,A+64'h300,             1'b0), 106);
    run_vec(mk(1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,64'h0,    1'b1,A+64'h304,1'b0,32'h6666_6666,A+64'h300,             1'b0), 107);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
